// File: rtl/pipelined_decode_unit_if.sv
// Decode-stage bundle interface.
// Groups the fetch word, the writeback port, the EX-side hazard/backpressure
// inputs, the flush request and the registered ID/EX bundle.
//   master : fetch/execute side (drives in, writeback, ex_*, flush)
//   slave  : decode stage (drives stall_fetch and the out_* bundle)
interface pipelined_decode_unit_if #(
    parameter int DATA_W     = 16,
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3
) ();
    logic [INSTR_W-1:0]    in;
    logic                  in_valid;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  ex_load;
    logic [REG_ADDR_W-1:0] ex_dst_addr;
    logic                  ex_ready;
    logic                  flush;
    logic                  stall_fetch;
    logic                  out_valid;
    logic [DATA_W-1:0]     out_rsrc;
    logic [DATA_W-1:0]     out_rdst;
    logic [REG_ADDR_W-1:0] out_rsrc_addr;
    logic [REG_ADDR_W-1:0] out_rdst_addr;
    logic [DATA_W-1:0]     out_imm;
    logic [4:0]            out_opcode;

    modport master (
        output in, in_valid, wb_en, wb_addr, wb_data,
               ex_load, ex_dst_addr, ex_ready, flush,
        input  stall_fetch, out_valid, out_rsrc, out_rdst,
               out_rsrc_addr, out_rdst_addr, out_imm, out_opcode
    );

    modport slave (
        input  in, in_valid, wb_en, wb_addr, wb_data,
               ex_load, ex_dst_addr, ex_ready, flush,
        output stall_fetch, out_valid, out_rsrc, out_rdst,
               out_rsrc_addr, out_rdst_addr, out_imm, out_opcode
    );
endinterface

// File: rtl/pipelined_decode_unit.sv
// Instruction decode stage.
// Owns the register file (with same-cycle writeback bypass), assembles one-
// and two-word instructions, inserts bubbles on load-use hazards, honours EX
// backpressure and flush, and registers the ID/EX bundle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   dec   : decode bundle interface (slave side), see pipelined_decode_unit_if
module pipelined_decode_unit #(
    parameter int DATA_W     = 16,
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipelined_decode_unit_if.slave  dec
);
    localparam int NREG = 2 ** REG_ADDR_W;
    localparam logic [0:0] S_INSTR = 1'b0;
    localparam logic [0:0] S_IMM   = 1'b1;

    logic [0:0]            state_r;
    logic [10:0]           first_hi_r;   // In[15:5] of the latched first word
    logic [DATA_W-1:0]     regfile_r [NREG];
    logic                  out_valid_r;
    logic [DATA_W-1:0]     out_rsrc_r;
    logic [DATA_W-1:0]     out_rdst_r;
    logic [REG_ADDR_W-1:0] out_rsrc_addr_r;
    logic [REG_ADDR_W-1:0] out_rdst_addr_r;
    logic [DATA_W-1:0]     out_imm_r;
    logic [4:0]            out_opcode_r;

    logic [4:0]            cur_op_s;
    logic [REG_ADDR_W-1:0] cur_rsrc_s;
    logic [REG_ADDR_W-1:0] cur_rdst_s;
    logic [DATA_W-1:0]     rsrc_val_s;
    logic [DATA_W-1:0]     rdst_val_s;
    logic                  hz_s;
    logic                  two_word_s;
    logic [DATA_W-1:0]     short_imm_s;
    logic [DATA_W-1:0]     long_imm_s;

    // Map a 3-bit instruction register field onto REG_ADDR_W bits (truncate or zero-pad).
    function automatic logic [REG_ADDR_W-1:0] field_addr(input logic [2:0] f);
        logic [REG_ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < 3 && i < REG_ADDR_W; i++) begin
            r[i] = f[i];
        end
        return r;
    endfunction

    // Zero-extend a full instruction word to operand width.
    function automatic logic [DATA_W-1:0] zext_word(input logic [INSTR_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = '0;
        r[INSTR_W-1:0] = w;
        return r;
    endfunction

    // Current instruction fields, bypassed register reads and hazard detection.
    always_comb begin
        if (state_r == S_IMM) begin
            cur_op_s   = first_hi_r[10:6];
            cur_rsrc_s = field_addr(first_hi_r[5:3]);
            cur_rdst_s = field_addr(first_hi_r[2:0]);
        end else begin
            cur_op_s   = dec.in[15:11];
            cur_rsrc_s = field_addr(dec.in[10:8]);
            cur_rdst_s = field_addr(dec.in[7:5]);
        end

        if (dec.wb_en && (dec.wb_addr == cur_rsrc_s)) begin
            rsrc_val_s = dec.wb_data;
        end else begin
            rsrc_val_s = regfile_r[cur_rsrc_s];
        end

        if (dec.wb_en && (dec.wb_addr == cur_rdst_s)) begin
            rdst_val_s = dec.wb_data;
        end else begin
            rdst_val_s = regfile_r[cur_rdst_s];
        end

        // In S_IMM the latched word is always live; in S_INSTR only a valid fetch word counts.
        if ((state_r == S_IMM) || dec.in_valid) begin
            hz_s = dec.ex_load &&
                   ((dec.ex_dst_addr == cur_rsrc_s) || (dec.ex_dst_addr == cur_rdst_s));
        end else begin
            hz_s = 1'b0;
        end

        two_word_s  = (dec.in[15:13] == 3'b110);
        short_imm_s = {{(DATA_W-5){dec.in[4]}}, dec.in[4:0]};
        long_imm_s  = zext_word(dec.in);
    end

    // Fetch must hold its word on a hazard or backpressure, but never while flushing.
    always_comb begin
        if (dec.flush) begin
            dec.stall_fetch = 1'b0;
        end else begin
            dec.stall_fetch = hz_s || !dec.ex_ready;
        end
    end

    // Register file: cleared on reset, written whenever writeback is enabled (even during flush).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regfile_r[i] <= '0;
            end
        end else if (dec.wb_en) begin
            regfile_r[dec.wb_addr] <= dec.wb_data;
        end
    end

    // Decode FSM and ID/EX bundle registers, in flush > backpressure > hazard > decode priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= S_INSTR;
            first_hi_r      <= 11'd0;
            out_valid_r     <= 1'b0;
            out_rsrc_r      <= '0;
            out_rdst_r      <= '0;
            out_rsrc_addr_r <= '0;
            out_rdst_addr_r <= '0;
            out_imm_r       <= '0;
            out_opcode_r    <= 5'd0;
        end else if (dec.flush) begin
            out_valid_r <= 1'b0;
            state_r     <= S_INSTR;
            first_hi_r  <= 11'd0;
        end else if (!dec.ex_ready) begin
            out_valid_r <= out_valid_r;
            state_r     <= state_r;
        end else if (hz_s) begin
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                S_INSTR: begin
                    if (!dec.in_valid) begin
                        out_valid_r <= 1'b0;
                    end else if (two_word_s) begin
                        first_hi_r  <= dec.in[15:5];
                        out_valid_r <= 1'b0;
                        state_r     <= S_IMM;
                    end else begin
                        out_valid_r     <= 1'b1;
                        out_rsrc_r      <= rsrc_val_s;
                        out_rdst_r      <= rdst_val_s;
                        out_rsrc_addr_r <= cur_rsrc_s;
                        out_rdst_addr_r <= cur_rdst_s;
                        out_imm_r       <= short_imm_s;
                        out_opcode_r    <= cur_op_s;
                    end
                end
                S_IMM: begin
                    if (dec.in_valid) begin
                        out_valid_r     <= 1'b1;
                        out_rsrc_r      <= rsrc_val_s;
                        out_rdst_r      <= rdst_val_s;
                        out_rsrc_addr_r <= cur_rsrc_s;
                        out_rdst_addr_r <= cur_rdst_s;
                        out_imm_r       <= long_imm_s;
                        out_opcode_r    <= cur_op_s;
                        state_r         <= S_INSTR;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= S_INSTR;
                end
            endcase
        end
    end

    assign dec.out_valid     = out_valid_r;
    assign dec.out_rsrc      = out_rsrc_r;
    assign dec.out_rdst      = out_rdst_r;
    assign dec.out_rsrc_addr = out_rsrc_addr_r;
    assign dec.out_rdst_addr = out_rdst_addr_r;
    assign dec.out_imm       = out_imm_r;
    assign dec.out_opcode    = out_opcode_r;
endmodule
